// File: rtl/rgbw_fader_pkg.sv
// Shared constants and state encoding for the RGBW duty-word fader.
package rgbw_fader_pkg;
  localparam int CH_NUM = 4;
  localparam int DW     = 8;
  localparam int DIVW   = 16;

  typedef enum logic {
    IDLE = 1'b0,
    FADE = 1'b1
  } state_t;
endpackage

// File: rtl/rgbw_fader_if.sv
// Load/target/duty bundle between a fade controller and the fader.
interface rgbw_fader_if;
  import rgbw_fader_pkg::*;

  logic            load;
  logic            ready;
  logic            busy;
  logic            done;
  logic [DW-1:0]   tgt0;
  logic [DW-1:0]   tgt1;
  logic [DW-1:0]   tgt2;
  logic [DW-1:0]   tgt3;
  logic [DIVW-1:0] step_div;
  logic [DW-1:0]   duty0;
  logic [DW-1:0]   duty1;
  logic [DW-1:0]   duty2;
  logic [DW-1:0]   duty3;

  modport master (
    output load, tgt0, tgt1, tgt2, tgt3, step_div,
    input  ready, busy, done, duty0, duty1, duty2, duty3
  );

  modport slave (
    input  load, tgt0, tgt1, tgt2, tgt3, step_div,
    output ready, busy, done, duty0, duty1, duty2, duty3
  );
endinterface

// File: rtl/rgbw_fader_channel.sv
// One fader lane: duty register chasing a latched target by one LSB per step.
module fader_channel #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic         i_step,
  input  logic [W-1:0] i_tgt,
  output logic [W-1:0] o_duty,
  output logic         o_at_target_next
);
  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] r_duty;
  logic [W-1:0] r_tgt;
  logic [W-1:0] w_duty_next;

  // Movement is always toward the target, so +1/-1 can never wrap.
  always_comb begin
    w_duty_next = r_duty;
    if (r_duty < r_tgt)
      w_duty_next = r_duty + ONE;
    else if (r_duty > r_tgt)
      w_duty_next = r_duty - ONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_duty <= '0;
      r_tgt  <= '0;
    end else begin
      if (i_load)
        r_tgt <= i_tgt;
      if (i_step)
        r_duty <= w_duty_next;
    end
  end

  assign o_duty           = r_duty;
  assign o_at_target_next = (w_duty_next == r_tgt);
endmodule

// File: rtl/rgbw_fader.sv
// RGBW fader: latches targets on load, then steps four duty words toward them.
module rgbw_fader
  import rgbw_fader_pkg::*;
(
  input logic          clk,
  input logic          reset,
  input logic          clk_half,
  rgbw_fader_if.slave  bus
);
  localparam logic [DIVW-1:0] CNT_ONE = DIVW'(1);

  state_t            r_state;
  state_t            w_state_next;
  logic [DIVW-1:0]   r_cnt;
  logic [DIVW-1:0]   r_div;
  logic              r_done;
  logic              w_en;
  logic              w_accept;
  logic              w_tick;
  logic              w_finish;
  logic              w_ready;
  logic              w_busy;
  logic [CH_NUM-1:0] w_at;
  logic [DW-1:0]     w_tgt  [CH_NUM];
  logic [DW-1:0]     w_duty [CH_NUM];

  assign w_en     = ~clk_half;
  assign w_accept = w_en && (r_state == IDLE) && bus.load;
  assign w_tick   = w_en && (r_state == FADE) && (r_cnt == r_div);
  assign w_finish = w_tick && (&w_at);

  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    w_busy       = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (w_accept)
          w_state_next = FADE;
      end
      FADE: begin
        w_busy = 1'b1;
        if (w_finish)
          w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Every register holds on clk_half-high edges so this block tracks the PWM stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_div   <= '0;
      r_done  <= 1'b0;
    end else if (w_en) begin
      r_state <= w_state_next;
      r_done  <= w_finish;
      if (w_accept) begin
        r_div <= bus.step_div;
        r_cnt <= '0;
      end else if (r_state == FADE) begin
        r_cnt <= w_tick ? '0 : r_cnt + CNT_ONE;
      end
    end
  end

  assign w_tgt[0] = bus.tgt0;
  assign w_tgt[1] = bus.tgt1;
  assign w_tgt[2] = bus.tgt2;
  assign w_tgt[3] = bus.tgt3;

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    fader_channel #(.W(DW)) u_ch (
      .clk              (clk),
      .reset            (reset),
      .i_load           (w_accept),
      .i_step           (w_tick),
      .i_tgt            (w_tgt[g]),
      .o_duty           (w_duty[g]),
      .o_at_target_next (w_at[g])
    );
  end

  assign bus.duty0 = w_duty[0];
  assign bus.duty1 = w_duty[1];
  assign bus.duty2 = w_duty[2];
  assign bus.duty3 = w_duty[3];
  assign bus.ready = w_ready;
  assign bus.busy  = w_busy;
  assign bus.done  = r_done;
endmodule

// File: tb/tb_rgbw_fader.sv
// Directed bench for rgbw_fader with a per-cycle behavioural reference.
module tb_rgbw_fader;
  import rgbw_fader_pkg::*;

  logic clk      = 1'b0;
  logic reset    = 1'b1;
  logic clk_half = 1'b0;
  logic hold     = 1'b0;

  rgbw_fader_if bus();

  rgbw_fader dut (
    .clk      (clk),
    .reset    (reset),
    .clk_half (clk_half),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    clk_half = hold ? 1'b1 : ~clk_half;
  end

  int compared   = 0;
  int mismatched = 0;

  int m_duty [4];
  int m_tgt  [4];
  bit m_busy;
  bit m_done;
  int m_div;
  int m_k;
  int edges;
  int m_acc_edge;
  int m_done_edge;
  int done_pulses;
  bit prev_done;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Reference: a step happens every (div+1)-th enabled edge after accept.
  initial begin
    for (int c = 0; c < 4; c++) begin m_duty[c] = 0; m_tgt[c] = 0; end
    m_busy = 0; m_done = 0; m_div = 0; m_k = 0; edges = 0;
    m_acc_edge = 0; m_done_edge = 0; done_pulses = 0; prev_done = 0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        for (int c = 0; c < 4; c++) begin m_duty[c] = 0; m_tgt[c] = 0; end
        m_busy = 0; m_done = 0; m_div = 0; m_k = 0;
      end else if (clk_half == 1'b0) begin
        edges++;
        m_done = 0;
        if (!m_busy) begin
          if (bus.load) begin
            m_tgt[0] = int'(bus.tgt0);
            m_tgt[1] = int'(bus.tgt1);
            m_tgt[2] = int'(bus.tgt2);
            m_tgt[3] = int'(bus.tgt3);
            m_div = int'(bus.step_div);
            m_k = 0;
            m_busy = 1;
            m_acc_edge = edges;
          end
        end else begin
          m_k++;
          if (m_k % (m_div + 1) == 0) begin
            bit all_eq;
            all_eq = 1;
            for (int c = 0; c < 4; c++) begin
              if (m_duty[c] < m_tgt[c]) m_duty[c]++;
              else if (m_duty[c] > m_tgt[c]) m_duty[c]--;
              if (m_duty[c] != m_tgt[c]) all_eq = 0;
            end
            if (all_eq) begin
              m_busy = 0;
              m_done = 1;
              m_done_edge = edges;
            end
          end
        end
      end
      #1;
      compared++;
      if (int'(bus.duty0) != m_duty[0] || int'(bus.duty1) != m_duty[1] ||
          int'(bus.duty2) != m_duty[2] || int'(bus.duty3) != m_duty[3] ||
          bus.ready !== !m_busy || bus.busy !== m_busy || bus.done !== m_done) begin
        mismatched++;
        $display("FAIL cycle t=%0t: got duty=%0d/%0d/%0d/%0d ready=%b busy=%b done=%b, required duty=%0d/%0d/%0d/%0d ready=%b busy=%b done=%b",
                 $time, bus.duty0, bus.duty1, bus.duty2, bus.duty3, bus.ready, bus.busy, bus.done,
                 m_duty[0], m_duty[1], m_duty[2], m_duty[3], !m_busy, m_busy, m_done);
      end
      if (reset) prev_done = 0;
      else begin
        if (bus.done === 1'b1 && !prev_done) done_pulses++;
        prev_done = (bus.done === 1'b1);
      end
    end
  end

  task automatic do_load(input int t0, input int t1, input int t2, input int t3, input int d);
    int n;
    @(negedge clk);
    bus.load     = 1'b1;
    bus.tgt0     = DW'(t0);
    bus.tgt1     = DW'(t1);
    bus.tgt2     = DW'(t2);
    bus.tgt3     = DW'(t3);
    bus.step_div = DIVW'(d);
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (clk_half !== 1'b0 && n < 8);
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    while (n < budget && !seen) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.done === 1'b1) seen = 1;
    end
    if (!seen) begin
      compared++;
      mismatched++;
      $display("FAIL %s: timeout waiting for done, got 0 required 1", name);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1);
  end

  initial begin
    int pulses0;
    int n;
    bus.load = 1'b0;
    bus.tgt0 = '0; bus.tgt1 = '0; bus.tgt2 = '0; bus.tgt3 = '0;
    bus.step_div = '0;
    repeat (3) @(negedge clk);
    check("reset_ready", int'(bus.ready), 1);
    check("reset_busy",  int'(bus.busy), 0);
    reset = 1'b0;

    // Basic fade, step every 2 enabled edges.
    do_load(3, 0, 0, 0, 1);
    wait_done("t2_done", 60);
    check("t2_latency", m_done_edge - m_acc_edge, 6);
    check("t2_duty0", int'(bus.duty0), 3);
    check("t2_ready_with_done", int'(bus.ready), 1);

    // Load while busy must be ignored.
    pulses0 = done_pulses;
    do_load(20, 5, 0, 0, 1);
    repeat (10) @(posedge clk);
    do_load(99, 99, 99, 99, 0);
    wait_done("t4_done", 200);
    check("t4_latency", m_done_edge - m_acc_edge, 34);
    check("t4_duty0", int'(bus.duty0), 20);
    check("t4_duty1", int'(bus.duty1), 5);
    repeat (8) @(posedge clk);
    check("t4_single_done", done_pulses - pulses0, 1);

    // Mixed directions, step every enabled edge.
    do_load(10, 200, 50, 50, 0);
    wait_done("t3_setup_done", 600);
    check("t3_setup_latency", m_done_edge - m_acc_edge, 195);
    do_load(12, 197, 50, 255, 0);
    wait_done("t3_done", 600);
    check("t3_latency", m_done_edge - m_acc_edge, 205);
    check("t3_duty0", int'(bus.duty0), 12);
    check("t3_duty1", int'(bus.duty1), 197);
    check("t3_duty2", int'(bus.duty2), 50);
    check("t3_duty3", int'(bus.duty3), 255);

    // Targets equal to current duties.
    pulses0 = done_pulses;
    do_load(12, 197, 50, 255, 4);
    wait_done("t5_done", 40);
    check("t5_latency", m_done_edge - m_acc_edge, 5);
    check("t5_duty3", int'(bus.duty3), 255);
    repeat (6) @(posedge clk);
    check("t5_single_done", done_pulses - pulses0, 1);

    // Enable gating freezes the fade mid-way.
    do_load(20, 197, 50, 250, 2);
    repeat (12) @(posedge clk);
    @(negedge clk);
    hold = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("t6_busy_frozen", int'(bus.busy), 1);
    @(negedge clk);
    hold = 1'b0;
    wait_done("t6_done", 100);
    check("t6_latency", m_done_edge - m_acc_edge, 24);
    check("t6_duty0", int'(bus.duty0), 20);
    check("t6_duty3", int'(bus.duty3), 250);

    // Asynchronous reset in the middle of a ramp.
    do_load(100, 197, 50, 250, 0);
    n = 0;
    while (n < 200 && int'(bus.duty0) != 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("t1_reached_40", int'(bus.duty0), 40);
    #2;
    reset = 1'b1;
    #1;
    check("t1_duty0", int'(bus.duty0), 0);
    check("t1_duty3", int'(bus.duty3), 0);
    check("t1_ready", int'(bus.ready), 1);
    check("t1_busy",  int'(bus.busy), 0);
    check("t1_done",  int'(bus.done), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("t1_idle_after", int'(bus.ready), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
